// File: rtl/vpg_pkg.sv
// Timing defaults and shared types for the display-side raster stream.
package vpg_pkg;

  localparam int VPG_H_ACTIVE = 320;
  localparam int VPG_H_FP     = 8;
  localparam int VPG_H_SYNC   = 32;
  localparam int VPG_H_BP     = 40;
  localparam int VPG_H_TOTAL  = VPG_H_ACTIVE + VPG_H_FP + VPG_H_SYNC + VPG_H_BP;

  localparam int VPG_V_ACTIVE = 240;
  localparam int VPG_V_FP     = 3;
  localparam int VPG_V_SYNC   = 4;
  localparam int VPG_V_BP     = 6;
  localparam int VPG_V_TOTAL  = VPG_V_ACTIVE + VPG_V_FP + VPG_V_SYNC + VPG_V_BP;

  localparam int VPG_H_SYNC_START = VPG_H_ACTIVE + VPG_H_FP;
  localparam int VPG_H_SYNC_END   = VPG_H_SYNC_START + VPG_H_SYNC;
  localparam int VPG_V_SYNC_START = VPG_V_ACTIVE + VPG_V_FP;
  localparam int VPG_V_SYNC_END   = VPG_V_SYNC_START + VPG_V_SYNC;

  localparam int VPG_PRIME_LVL = 64;
  localparam int CNT_W         = 12;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [23:0]      rgb24_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic sof;
  } vpg_ctl_t;

  function automatic cnt_t to_cnt(input int v);
    return cnt_t'(v);
  endfunction

endpackage

// File: rtl/vpg_stream_out_timing.sv
// Raster counters and decode; everything reads as idle (all zero) until run_i.
module vpg_timing import vpg_pkg::*; #(
  parameter int H_ACTIVE = VPG_H_ACTIVE,
  parameter int H_FP     = VPG_H_FP,
  parameter int H_SYNC   = VPG_H_SYNC,
  parameter int H_BP     = VPG_H_BP,
  parameter int V_ACTIVE = VPG_V_ACTIVE,
  parameter int V_FP     = VPG_V_FP,
  parameter int V_SYNC   = VPG_V_SYNC,
  parameter int V_BP     = VPG_V_BP
) (
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     run_i,
  output vpg_ctl_t ctl_o
);

  localparam cnt_t H_ACT  = to_cnt(H_ACTIVE);
  localparam cnt_t H_SS   = to_cnt(H_ACTIVE + H_FP);
  localparam cnt_t H_SE   = to_cnt(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_LAST = to_cnt(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_ACT  = to_cnt(V_ACTIVE);
  localparam cnt_t V_SS   = to_cnt(V_ACTIVE + V_FP);
  localparam cnt_t V_SE   = to_cnt(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_LAST = to_cnt(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  cnt_t h_q, h_d, v_q, v_d;
  vpg_ctl_t raw;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run_i) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    raw.de  = (h_q < H_ACT) && (v_q < V_ACT);
    raw.hs  = (h_q >= H_SS) && (h_q < H_SE);
    raw.vs  = (v_q >= V_SS) && (v_q < V_SE);
    raw.sof = (h_q == '0) && (v_q == '0);
    ctl_o   = run_i ? raw : '0;
  end

endmodule

// File: rtl/vpg_stream_out.sv
// Drains the SDRAM read FIFO into a free-running raster; blanks until primed,
// substitutes black and counts when the FIFO runs dry.
module vpg_stream_out import vpg_pkg::*; #(
  parameter int   H_ACTIVE  = VPG_H_ACTIVE,
  parameter int   H_FP      = VPG_H_FP,
  parameter int   H_SYNC    = VPG_H_SYNC,
  parameter int   H_BP      = VPG_H_BP,
  parameter int   V_ACTIVE  = VPG_V_ACTIVE,
  parameter int   V_FP      = VPG_V_FP,
  parameter int   V_SYNC    = VPG_V_SYNC,
  parameter int   V_BP      = VPG_V_BP,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   PRIME_LVL = VPG_PRIME_LVL
) (
  input  logic        vpg_pclk,
  input  logic        reset,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  input  logic [8:0]  rd_usedw,
  output logic        rd_req,
  output logic        vpg_de,
  output logic        vpg_hs,
  output logic        vpg_vs,
  output logic [23:0] vpg_data,
  output logic        frame_start,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [8:0] PRIME_THR = 9'(PRIME_LVL);

  state_t      state_q;
  vpg_ctl_t    ctl, s1_ctl_q;
  logic        s1_pop_q, starve;
  logic        de_q, hs_q, vs_q, fs_q, uf_q;
  rgb24_t      data_q;
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic        unused_pad;

  vpg_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk_i   (vpg_pclk),
    .reset_i (reset),
    .run_i   (state_q == RUN),
    .ctl_o   (ctl)
  );

  // ctl is already zero outside RUN, so these need no extra state gating.
  assign rd_req   = ctl.de && !rd_empty;
  assign starve   = ctl.de && rd_empty;
  assign uf_cnt_d = (starve && (uf_cnt_q != 16'hFFFF)) ? uf_cnt_q + 16'd1 : uf_cnt_q;

  // The FIFO word's top byte is padding.
  assign unused_pad = ^rd_data[31:24];

  always_ff @(posedge vpg_pclk) begin
    if (reset) begin
      state_q  <= IDLE;
      s1_ctl_q <= '0;
      s1_pop_q <= 1'b0;
      de_q     <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      fs_q     <= 1'b0;
      data_q   <= '0;
      uf_q     <= 1'b0;
      uf_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (rd_usedw >= PRIME_THR) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      s1_ctl_q <= ctl;
      s1_pop_q <= rd_req;
      de_q     <= s1_ctl_q.de;
      hs_q     <= s1_ctl_q.hs ? HS_POL : ~HS_POL;
      vs_q     <= s1_ctl_q.vs ? VS_POL : ~VS_POL;
      fs_q     <= s1_ctl_q.sof;
      data_q   <= (s1_ctl_q.de && s1_pop_q) ? rgb24_t'(rd_data[23:0]) : '0;
      if (starve) uf_q <= 1'b1;
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign vpg_de        = de_q;
  assign vpg_hs        = hs_q;
  assign vpg_vs        = vs_q;
  assign vpg_data      = data_q;
  assign frame_start   = fs_q;
  assign underflow     = uf_q;
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_vpg_stream_out.sv
// Scoreboarded bench for vpg_stream_out on a shortened (17-line) raster.
module tb_vpg_stream_out;

  localparam int HA = 320, HFP = 8, HSW = 32, HBP = 40, HT = 400;
  localparam int VA = 12,  VFP = 1, VSW = 2,  VBP = 2,  VT = 17;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rd_data = '0;
  logic        rd_empty = 1'b1;
  logic [8:0]  rd_usedw = '0;
  logic        rd_req, de, hs, vs, fs, uf;
  logic [23:0] data;
  logic [15:0] ufc;

  int n_checks = 0;
  int n_fail = 0;
  int empty_pops = 0;

  logic [31:0] fifo[$];
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  vpg_stream_out #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HS_POL (1'b0), .VS_POL (1'b0), .PRIME_LVL (64)
  ) dut (
    .vpg_pclk      (clk),
    .reset         (reset),
    .rd_data       (rd_data),
    .rd_empty      (rd_empty),
    .rd_usedw      (rd_usedw),
    .rd_req        (rd_req),
    .vpg_de        (de),
    .vpg_hs        (hs),
    .vpg_vs        (vs),
    .vpg_data      (data),
    .frame_start   (fs),
    .underflow     (uf),
    .underflow_cnt (ufc)
  );

  // Normal-mode read FIFO: q updates one edge after the pop request.
  always @(posedge clk) begin
    if (rd_req) begin
      if (rd_empty || fifo.size() == 0) empty_pops++;
      else rd_data <= fifo.pop_front();
    end
    rd_empty <= (fifo.size() == 0);
  end

  task automatic fill(input int n, input logic [31:0] first, input logic [31:0] base);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? first : (base | 32'(i + 1));
      fifo.push_back(w);
      exp_q.push_back(w[23:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_usedw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rd_req, de, hs, vs, fs, uf} !== 6'b001100) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 001100", {rd_req, de, hs, vs, fs, uf});
    end
    n_checks++;
    if (data !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data); end
    n_checks++;
    if (ufc !== 16'h0) begin n_fail++; $display("FAIL reset_ufcnt: got %0d want 0", ufc); end
  endtask

  task automatic test_idle_hold();
    fill(1000, 32'h0000_0001, 32'h0);
    reset = 1'b0;
    rd_usedw = 9'd63;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_req, de} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_hold cyc %0d: rd_req/de got %b want 00", i, {rd_req, de});
      end
    end
  endtask

  // Releases priming; returns on the negedge where the first pixel must be out.
  task automatic test_prime_latency(input logic [23:0] first_px);
    rd_usedw = 9'd64;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (de !== (c == 3)) begin
        n_fail++;
        $display("FAIL prime_de cyc %0d: got %b want %b", c, de, (c == 3));
      end
    end
    n_checks++;
    if (data !== first_px) begin n_fail++; $display("FAIL first_px: got %h want %h", data, first_px); end
    n_checks++;
    if (fs !== 1'b1) begin n_fail++; $display("FAIL first_fs: got %b want 1", fs); end
  endtask

  // Checks ncyc output cycles starting at raster position t0, then steps one more cycle.
  task automatic test_raster(input int ncyc, input int t0, input int uf_t, input int uf_exp);
    int t, h, ln;
    logic [3:0]  ectl;
    logic [23:0] epx;
    for (int i = 0; i < ncyc; i++) begin
      t  = t0 + i;
      h  = t % HT;
      ln = (t / HT) % VT;
      ectl[3] = (h < HA) && (ln < VA);
      ectl[2] = !((h >= HA + HFP) && (h < HA + HFP + HSW));
      ectl[1] = !((ln >= VA + VFP) && (ln < VA + VFP + VSW));
      ectl[0] = (t % FRAME) == 0;
      epx = 24'h0;
      if (ectl[3] && exp_q.size() > 0) epx = exp_q.pop_front();
      n_checks++;
      if ({de, hs, vs, fs} !== ectl) begin
        n_fail++;
        $display("FAIL raster t=%0d: de/hs/vs/fs got %b want %b", t, {de, hs, vs, fs}, ectl);
      end
      n_checks++;
      if (data !== epx) begin
        n_fail++;
        $display("FAIL pixel t=%0d: got %h want %h", t, data, epx);
      end
      if (t == uf_t) begin
        n_checks++;
        if (ufc !== 16'(uf_exp) || uf !== (uf_exp != 0)) begin
          n_fail++;
          $display("FAIL underflow t=%0d: got %b/%0d want %b/%0d", t, uf, ufc, (uf_exp != 0), uf_exp);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_empty_pop();
    n_checks++;
    if (empty_pops !== 0) begin
      n_fail++;
      $display("FAIL pop_on_empty: got %0d want 0", empty_pops);
    end
  endtask

  task automatic test_reset_midframe();
    reset = 1'b1;
    rd_usedw = '0;
    @(negedge clk);
    n_checks++;
    if ({rd_req, de, hs, vs, fs, uf} !== 6'b001100) begin
      n_fail++;
      $display("FAIL midreset_ctl: got %b want 001100", {rd_req, de, hs, vs, fs, uf});
    end
    n_checks++;
    if (data !== 24'h0 || ufc !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset_data: got %h/%0d want 0/0", data, ufc);
    end
  endtask

  task automatic test_reprime();
    fifo.delete();
    exp_q.delete();
    fill(2 * HA, 32'hAB12_3456, 32'hFF00_0000);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({de, uf} !== 2'b00 || ufc !== 16'h0) begin
      n_fail++;
      $display("FAIL reprime_idle: de/uf got %b cnt %0d want 00 cnt 0", {de, uf}, ufc);
    end
    test_prime_latency(24'h123456);
    test_raster(3 * HT, 0, 2 * HT - 10, 0);
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_prime_latency(24'h000001);
    test_raster(FRAME + 5 * HT + 50, 0, 6000, VA * HA - 1000);
    test_no_empty_pop();
    test_reset_midframe();
    test_reprime();
    test_no_empty_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
